// File: rtl/nonce_uart_pkg.sv
// Shared baud math and receiver state encoding for the nonce hub
// and the serial transmitter.
package nonce_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic int calc_half(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte framer: synchronizes rxd and recovers bytes with a
// mid-bit sampling FSM; flags bad stop bits.
module uart_byte_rx
    import nonce_uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy,
    output logic       start
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int HALF  = calc_half(DIV);
    localparam int CNT_W = $clog2(DIV + 1);

    localparam logic [CNT_W-1:0] DIV_C  = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    rx_state_t        state;
    rx_state_t        state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       bitn;
    logic [2:0]       bitn_n;
    logic [7:0]       shreg;
    logic [7:0]       shreg_n;
    logic             tick;

    // A load of N expires on the Nth clock after loading.
    assign tick = (cnt == ONE_C);
    assign data = shreg;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shreg <= '0;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            state <= state_n;
            cnt   <= cnt_n;
            bitn  <= bitn_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bitn_n     = bitn;
        shreg_n    = shreg;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        start      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!sync2) begin
                    state_n = START;
                    cnt_n   = HALF_C;
                    start   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (!sync2) begin
                        state_n = DATA;
                        cnt_n   = DIV_C;
                        bitn_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_n = {sync2, shreg[7:1]};
                    cnt_n   = DIV_C;
                    bitn_n  = bitn + 1'b1;
                    if (bitn == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (sync2) begin
                        byte_valid = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_n   = WAIT_IDLE;
                        cnt_n     = DIV_C;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            WAIT_IDLE: begin
                // Need a full bit time of continuous high before rearming.
                if (!sync2) begin
                    cnt_n = DIV_C;
                end else if (tick) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/nonce_uart_rx.sv
// Nonce receiver: assembles little-endian words from framed bytes and
// drops stale partial words after an inter-byte idle timeout.
module nonce_uart_rx
    import nonce_uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int WORD_BYTES   = 4,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rxd,
    output logic [WORD_BYTES*8-1:0] nonce,
    output logic                    new_nonce,
    output logic                    frame_err,
    output logic                    busy
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int LIMIT = TIMEOUT_BITS * DIV;
    localparam int TO_W  = $clog2(LIMIT + 2);
    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int W     = WORD_BYTES * 8;

    localparam logic [IDX_W-1:0] LAST   = IDX_W'(WORD_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LIM = TO_W'(LIMIT);
    localparam logic [TO_W-1:0]  TO_MAX = TO_W'(LIMIT + 1);

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ferr;
    logic             rx_busy;
    logic             rx_start;
    logic [W-1:0]     partial;
    logic [W-1:0]     assembled;
    logic [IDX_W-1:0] idx;
    logic [TO_W-1:0]  to_cnt;
    logic             timed_out;

    uart_byte_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_byte (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .data       (rx_data),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr),
        .busy       (rx_busy),
        .start      (rx_start)
    );

    assign busy      = rx_busy;
    assign timed_out = (to_cnt > TO_LIM);

    always_comb begin
        assembled = partial;
        assembled[{idx, 3'b000} +: 8] = rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nonce     <= '0;
            partial   <= '0;
            idx       <= '0;
            new_nonce <= 1'b0;
            frame_err <= 1'b0;
            to_cnt    <= '0;
        end else begin
            new_nonce <= 1'b0;
            frame_err <= rx_ferr;
            // Idle clocks since the last start bit, saturating.
            if (rx_start) begin
                to_cnt <= '0;
            end else if (!rx_busy && to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (rx_valid) begin
                partial <= assembled;
                if (idx == LAST) begin
                    nonce     <= assembled;
                    new_nonce <= 1'b1;
                    idx       <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else if (rx_ferr) begin
                idx <= '0;
            end else if (timed_out && idx != '0) begin
                idx <= '0;
            end
        end
    end

endmodule

// File: doc/nonce_uart_rx.md
NONCE_UART_RX -- requirements
Module: nonce_uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning the frequency of clk in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, meaning the serial bit rate.
REQ-003 SHALL have parameter WORD_BYTES, default 4, meaning the number of bytes per received word.
REQ-004 SHALL have parameter TIMEOUT_BITS, default 32, meaning the maximum idle gap between bytes of one word, in bit times.
REQ-005 SHALL have port clk, input, 1 bit: the single clock (the hub hash clock); all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port rxd, input, 1 bit: asynchronous serial line from one miner's TxD; idles high.
REQ-008 SHALL have port nonce, output, WORD_BYTES*8 bits: the last complete word received.
REQ-009 SHALL have port new_nonce, output, 1 bit: one-cycle pulse indicating that nonce has just been updated.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a stop-bit error.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM state is not IDLE.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer before any use; all timing is referenced to the synchronized line.
REQ-013 SHALL use DIV = (CLK_HZ + BAUD/2)/BAUD clocks per bit and HALF = DIV/2; counter widths SHALL be $clog2 of the maximum count.
REQ-014 SHALL implement the FSM states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-015 IDLE: a low synchronized line SHALL go to START and load the bit counter with HALF.
REQ-016 START: at counter expiry, if the line is low, SHALL go to DATA; if high (glitch), SHALL return to IDLE with no output and the partial word kept.
REQ-017 DATA: SHALL sample 8 bits, LSB first, one every DIV clocks at mid-bit, then go to STOP.
REQ-018 STOP: at mid-stop, a high line SHALL accept the byte and go to IDLE.
REQ-019 STOP: at mid-stop, a low line SHALL pulse frame_err, discard the byte and the partial word, and go to WAIT_IDLE.
REQ-020 WAIT_IDLE: SHALL stay until the line has been high for DIV consecutive clocks, then go to IDLE.
REQ-021 Accepted bytes SHALL assemble little-endian: the first byte of a word lands in nonce[7:0], byte k lands in nonce[8k+7:8k].
REQ-022 On acceptance of byte WORD_BYTES-1, SHALL update nonce and pulse new_nonce in the same cycle, then reset the byte index to 0.
REQ-023 nonce SHALL hold its value between words; partial words SHALL never appear on nonce.
REQ-024 When the byte index is nonzero, more than TIMEOUT_BITS*DIV clocks in IDLE SHALL reset the index to 0 and silently discard the partial word.
REQ-025 The timeout counter SHALL reset on every start-bit detect and SHALL saturate rather than wrap.
REQ-026 Back-to-back frames (a new start bit immediately after the stop bit) SHALL be received without loss.
REQ-027 new_nonce and frame_err SHALL never both be high in the same cycle.

Reset
REQ-028 With rst high, the FSM SHALL be in IDLE, the byte index 0, nonce 0, new_nonce 0, frame_err 0, busy 0, and the synchronizer flops 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; the first word after reset SHALL be received intact.

Structure
REQ-030 The FSM state enum and the DIV/HALF derivation functions SHALL live in a shared package, nonce_uart_pkg, so the hub and serial_transmit share the baud math.
REQ-031 Byte framing (synchronizer, START/DATA/STOP/WAIT_IDLE) SHALL be a sub-module, uart_byte_rx, which outputs a byte, a byte_valid pulse and frame_err. The top level SHALL perform word assembly and the timeout.

Verification (CLK_HZ=1_600_000, BAUD=100_000, so DIV=16)
REQ-032 Bytes 0x78,0x56,0x34,0x12, 8N1, back-to-back -> exactly one new_nonce pulse with nonce=0x12345678, arriving DIV/2+1 to DIV/2+3 clocks after the start of the last stop bit.
REQ-033 Second byte sent with stop bit 0 -> frame_err pulses once, no new_nonce; then 0xDEADBEEF (LSB byte first) -> nonce=0xDEADBEEF.
REQ-034 Send 2 bytes, idle 40 bit times, then send 4 bytes of 0xCAFEF00D -> single new_nonce with nonce=0xCAFEF00D; the stale bytes are discarded.
REQ-035 Low glitch of 4 clocks on an idle line -> no outputs, busy high for at most HALF+3 clocks, next word received correctly.
REQ-036 rst pulsed during the third byte -> nonce=0 and busy=0; then 0x00000001 -> nonce=0x00000001 with a single new_nonce pulse.
